countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_pkg.sv | 12 +
 rtl/countdown_timer_if.sv | 28 ++
 rtl/countdown_timer.sv | 108 ++++++++++
 tb/tb_countdown_timer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer.
package countdown_timer_pkg;

  localparam int unsigned DefaultWidth = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StExpire = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake, control strobes and status outputs of the countdown timer.
interface countdown_timer_if
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);
  logic             tick_i;
  logic             load_valid_i;
  logic             load_ready_o;
  logic [WIDTH-1:0] load_val_i;
  logic             periodic_i;
  logic             stop_i;
  logic             irq_clr_i;
  logic [WIDTH-1:0] q_o;
  logic             busy_o;
  logic             expire_o;
  logic             irq_o;

  modport master (
    output tick_i, load_valid_i, load_val_i, periodic_i, stop_i, irq_clr_i,
    input  load_ready_o, q_o, busy_o, expire_o, irq_o
  );

  modport slave (
    input  tick_i, load_valid_i, load_val_i, periodic_i, stop_i, irq_clr_i,
    output load_ready_o, q_o, busy_o, expire_o, irq_o
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot/periodic expiry and sticky interrupt.
// Define COUNTDOWN_TIMER_AUTORELOAD_EN to enable periodic auto-reload.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic               clk_i,
  input logic               rst_n_i,
  countdown_timer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             irq_q, irq_d;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
`else
  logic             unused_periodic;
  assign unused_periodic = bus.periodic_i;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    irq_d   = irq_q;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    reload_d   = reload_q;
    periodic_d = periodic_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.load_valid_i) begin
          count_d = bus.load_val_i;
          state_d = (bus.load_val_i == '0) ? StExpire : StRun;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
          reload_d   = bus.load_val_i;
          periodic_d = bus.periodic_i;
`endif
        end
      end
      StRun: begin
        if (bus.stop_i) begin
          count_d = '0;
          state_d = StIdle;
        end else if (bus.tick_i) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else begin
            count_d = '0;
            state_d = StExpire;
          end
        end
      end
      StExpire: begin
        count_d = '0;
        state_d = StIdle;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        // A zero reload means the load was one-shot whatever periodic_i said.
        if (!bus.stop_i && periodic_q && (reload_q != '0)) begin
          count_d = reload_q;
          state_d = StRun;
        end
`endif
      end
      default: begin
        count_d = '0;
        state_d = StIdle;
      end
    endcase

    // Expiry wins over a clear arriving on the entry edge or during the pulse.
    if ((state_d == StExpire) || (state_q == StExpire)) begin
      irq_d = 1'b1;
    end else if (bus.irq_clr_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      count_q <= '0;
      irq_q   <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_q   <= '0;
      periodic_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      irq_q   <= irq_d;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
`endif
    end
  end

  assign bus.load_ready_o = (state_q == StIdle);
  assign bus.busy_o       = (state_q != StIdle);
  assign bus.expire_o     = (state_q == StExpire);
  assign bus.q_o          = count_q;
  assign bus.irq_o        = irq_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: each driven cycle queues the expected post-edge outputs.
module tb_countdown_timer;

  localparam int unsigned W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  countdown_timer_if #(.WIDTH(W)) cif ();

  countdown_timer #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (cif)
  );

  typedef struct {
    string        tag;
    int           idx;
    logic [W-1:0] q;
    logic         busy;
    logic         expire;
    logic         irq;
    logic         ready;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_idx = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are applied on the falling edge; expectation is for after the next rising edge.
  task automatic drive(input string tag, input logic rst, input logic tick, input logic valid,
                       input logic [W-1:0] val, input logic per, input logic stop,
                       input logic clr, input logic [W-1:0] eq, input logic ebusy,
                       input logic eexp, input logic eirq, input logic erdy);
    exp_t e;
    @(negedge clk);
    rst_n            = rst;
    cif.tick_i       = tick;
    cif.load_valid_i = valid;
    cif.load_val_i   = val;
    cif.periodic_i   = per;
    cif.stop_i       = stop;
    cif.irq_clr_i    = clr;
    e.tag    = tag;
    e.idx    = step_idx;
    e.q      = eq;
    e.busy   = ebusy;
    e.expire = eexp;
    e.irq    = eirq;
    e.ready  = erdy;
    step_idx++;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t  e;
      string t;
      e = sb.pop_front();
      t = $sformatf("%s#%0d", e.tag, e.idx);
      check_val({t, ".q"},      32'(cif.q_o),          32'(e.q));
      check_val({t, ".busy"},   32'(cif.busy_o),       32'(e.busy));
      check_val({t, ".expire"}, 32'(cif.expire_o),     32'(e.expire));
      check_val({t, ".irq"},    32'(cif.irq_o),        32'(e.irq));
      check_val({t, ".ready"},  32'(cif.load_ready_o), 32'(e.ready));
    end
  end

  initial begin
    logic irq_e;
    cif.tick_i       = 1'b0;
    cif.load_valid_i = 1'b0;
    cif.load_val_i   = '0;
    cif.periodic_i   = 1'b0;
    cif.stop_i       = 1'b0;
    cif.irq_clr_i    = 1'b0;

    drive("rst", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    drive("rst", 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);

    // One-shot load 3, tick every cycle, then clear irq during and after the pulse.
    drive("s1_acc",     1, 1, 1, 3, 0, 0, 0,  3, 1, 0, 0, 0);
    drive("s1_t",       1, 1, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0);
    drive("s1_t",       1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0);
    drive("s1_exp",     1, 1, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0);
    drive("s5_clr_exp", 1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1);
    drive("s5_clr",     1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1);

    // Load 0 with periodic set: single immediate expiry, no repeat.
    drive("s3_acc",   1, 0, 1, 0, 1, 0, 0,  0, 1, 1, 1, 0);
    drive("s3_idle",  1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
    drive("s3_norep", 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1);

    // Load 10, stop together with tick at 5; a load attempt while busy is ignored.
    drive("s4_acc", 1, 1, 1, 10, 0, 0, 0,  10, 1, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      drive("s4_t", 1, 1, (k == 2), 99, 0, 0, 0,  W'(10 - k), 1, 0, 1, 0);
    end
    drive("s4_stop",      1, 1, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1);
    drive("s4_idle_stop", 1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1);
    drive("s4_stop_ld",   1, 0, 1, 2, 0, 1, 0,  2, 1, 0, 1, 0);
    drive("s4_t",         1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 1, 0);
    drive("s4_exp",       1, 1, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0);
    drive("s4_exp_stop",  1, 1, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1);

    // Load 9, hold without tick, count to 7, then reset mid-count.
    drive("s6_acc",  1, 0, 1, 9, 0, 0, 0,  9, 1, 0, 1, 0);
    drive("s6_hold", 1, 0, 0, 0, 0, 0, 0,  9, 1, 0, 1, 0);
    drive("s6_t",    1, 1, 0, 0, 0, 0, 0,  8, 1, 0, 1, 0);
    drive("s6_t",    1, 1, 0, 0, 0, 0, 0,  7, 1, 0, 1, 0);
    drive("s6_rst",  0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    drive("s6_post", 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);

    // Load 4 periodic, tick every 2nd cycle.
    drive("s2_acc", 1, 0, 1, 4, 1, 0, 0,  4, 1, 0, 0, 0);
    irq_e = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    for (int p = 0; p < 2; p++) begin
`else
    for (int p = 0; p < 1; p++) begin
`endif
      for (int k = 0; k < 7; k++) begin
        int ticks;
        ticks = k / 2 + 1;
        if (ticks == 4) begin
          irq_e = 1'b1;
          drive("s2_exp", 1, (k % 2 == 0), 0, 0, 0, 0, 0,  0, 1, 1, 1, 0);
        end else begin
          drive("s2_t", 1, (k % 2 == 0), 0, 0, 0, 0, 0,  W'(4 - ticks), 1, 0, irq_e, 0);
        end
      end
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      if (p == 0) begin
        drive("s2_reload", 1, 0, 0, 0, 0, 0, 0,  4, 1, 0, 1, 0);
      end else begin
        drive("s2_stop_rl", 1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1);
      end
`else
      drive("s2_oneshot", 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1);
`endif
    end
    drive("s2_idle", 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1);

    repeat (3) @(negedge clk);
    check_val("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
